// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage data-memory interface.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DONE = 2'd2
    } dmem_state_t;

    // Low byte-address bits that must be zero for a word access.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer: accepts a store when empty or when its
// current entry drains in the same cycle.
module dmem_wbuf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          drain,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          can_accept,
    output logic          valid_nxt,
    output logic [AW-1:0] addr_nxt,
    output logic [DW-1:0] data_nxt
);

    always_comb begin
        can_accept = !valid || drain;
        valid_nxt  = push || (valid && !drain);
        addr_nxt   = push ? push_addr : addr;
        data_nxt   = push ? push_data : data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            addr  <= addr_nxt;
            data  <= data_nxt;
        end
    end

endmodule

// File: rtl/dmem_if_m.sv
// MEM-stage data-memory interface: req/ack bus to variable-latency memory,
// posted store buffer, load FSM, stall request and stall-cycle counter.
module dmem_if_m
    import mips_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread_m,
    input  logic             memwrite_m,
    input  logic [AW-1:0]    aluout_m,
    input  logic [DW-1:0]    writedata_m,
    output logic [DW-1:0]    readdata_m,
    output logic             stall_m,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_ack,
    input  logic [DW-1:0]    mem_rdata,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_cnt
);

    dmem_state_t   state, state_nxt;
    logic          wb_valid, wb_valid_nxt, wb_can_accept;
    logic [AW-1:0] wb_addr, wb_addr_nxt;
    logic [DW-1:0] wb_data, wb_data_nxt;
    logic          drain_ack, rd_ack, push, stall_raw, misaligned;
    logic          req_nxt, we_nxt;
    logic [AW-1:0] addr_nxt, addr_aligned;
    logic [DW-1:0] wdata_nxt;

    dmem_wbuf #(
        .AW(AW),
        .DW(DW)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (addr_aligned),
        .push_data  (writedata_m),
        .drain      (drain_ack),
        .valid      (wb_valid),
        .addr       (wb_addr),
        .data       (wb_data),
        .can_accept (wb_can_accept),
        .valid_nxt  (wb_valid_nxt),
        .addr_nxt   (wb_addr_nxt),
        .data_nxt   (wb_data_nxt)
    );

    assign addr_aligned = {aluout_m[AW-1:2], 2'b00};
    assign misaligned   = |(aluout_m[1:0] & WORD_ALIGN_MASK);
    assign drain_ack    = wb_valid && mem_req && mem_we && mem_ack;
    assign rd_ack       = (state == RD_REQ) && mem_req && !mem_we && mem_ack;
    // Held low during reset so the hazard unit is released even if the
    // pipeline still presents a load.
    assign stall_m      = stall_raw && reset;

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (memwrite_m) begin
                    stall_raw = !wb_can_accept;
                    push      = wb_can_accept;
                end else if (memread_m) begin
                    stall_raw = 1'b1;
                    if (wb_can_accept) state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                stall_raw = 1'b1;
                if (rd_ack) state_nxt = RD_DONE;
            end
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next bus beat: a read owns the bus; otherwise the buffer drains.
    always_comb begin
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        if (state_nxt == RD_REQ) begin
            req_nxt  = 1'b1;
            addr_nxt = (state == RD_REQ) ? mem_addr : addr_aligned;
        end else if (wb_valid_nxt) begin
            req_nxt   = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = wb_addr_nxt;
            wdata_nxt = wb_data_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            readdata_m   <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            misalign_err <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            if (rd_ack) readdata_m <= mem_rdata;
            if (state == IDLE && (memread_m || memwrite_m) && misaligned) begin
                misalign_err <= 1'b1;
            end
            if (stall_m && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_dmem_if_m.sv
// Directed bench for dmem_if_m: stores, loads, ordering, misalignment, reset.
module tb_dmem_if_m;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread_m = 1'b0;
    logic        memwrite_m = 1'b0;
    logic [31:0] aluout_m = '0;
    logic [31:0] writedata_m = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] readdata_m, mem_addr, mem_wdata;
    logic        stall_m, mem_req, mem_we, misalign_err;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_if_m #(
        .AW(32),
        .DW(32),
        .CNT_W(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memread_m    (memread_m),
        .memwrite_m   (memwrite_m),
        .aluout_m     (aluout_m),
        .writedata_m  (writedata_m),
        .readdata_m   (readdata_m),
        .stall_m      (stall_m),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .misalign_err (misalign_err),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", readdata_m, 0);
        check("rst_stall", stall_m, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_mis", misalign_err, 0);
        reset = 1'b1;
        tick();

        // Store, drained with ack on the third request cycle.
        memwrite_m = 1'b1; aluout_m = 32'h40; writedata_m = 32'hDEADBEEF;
        #1 check("t1_stall_acc", stall_m, 0);
        tick();
        memwrite_m = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            mem_ack = (i == 3);
            #1;
            check("t1_req", mem_req, 1);
            check("t1_we", mem_we, 1);
            check("t1_addr", mem_addr, 32'h40);
            check("t1_wdata", mem_wdata, 32'hDEADBEEF);
            check("t1_stall", stall_m, 0);
            tick();
        end
        mem_ack = 1'b0;
        #1 check("t1_idle_req", mem_req, 0);

        // Load with empty buffer, ack on first request cycle.
        check("t2_cnt0", stall_cnt, 0);
        memread_m = 1'b1; aluout_m = 32'h80;
        #1 check("t2_stall0", stall_m, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        check("t2_req", mem_req, 1);
        check("t2_we", mem_we, 0);
        check("t2_addr", mem_addr, 32'h80);
        check("t2_stall1", stall_m, 1);
        tick();
        mem_ack = 1'b0;
        #1;
        check("t2_release", stall_m, 0);
        check("t2_rdata", readdata_m, 32'h12345678);
        check("t2_cnt", stall_cnt, 2);
        check("t2_state", 32'(dut.state), 32'(RD_DONE));
        tick();
        memread_m = 1'b0;
        #1;
        check("t2_idle_req", mem_req, 0);
        check("t2_hold", readdata_m, 32'h12345678);

        // Store then load to the same address; read waits for the write ack.
        memwrite_m = 1'b1; aluout_m = 32'h100; writedata_m = 32'h11111111;
        #1 check("t3_stall_acc", stall_m, 0);
        tick();
        memwrite_m = 1'b0; memread_m = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mem_ack = (i == 4);
            #1;
            check("t3_wait_stall", stall_m, 1);
            check("t3_wait_we", mem_we, 1);
            check("t3_wait_req", mem_req, 1);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        check("t3_rd_req", mem_req, 1);
        check("t3_rd_we", mem_we, 0);
        check("t3_rd_addr", mem_addr, 32'h100);
        tick();
        mem_ack = 1'b0;
        #1;
        check("t3_release", stall_m, 0);
        check("t3_rdata", readdata_m, 32'hCAFEF00D);
        check("t3_cnt", stall_cnt, 7);
        tick();
        memread_m = 1'b0;
        #1 check("t3_idle_req", mem_req, 0);

        // Back-to-back stores with a 5-cycle ack.
        memwrite_m = 1'b1; aluout_m = 32'h10; writedata_m = 32'hAAAA0010;
        #1 check("t4_stall_acc", stall_m, 0);
        tick();
        aluout_m = 32'h14; writedata_m = 32'hBBBB0014;
        for (int i = 1; i <= 5; i++) begin
            mem_ack = (i == 5);
            #1;
            check("t4_w1_addr", mem_addr, 32'h10);
            check("t4_w1_wdata", mem_wdata, 32'hAAAA0010);
            check("t4_w1_we", mem_we, 1);
            check("t4_w1_stall", stall_m, (i == 5) ? 32'd0 : 32'd1);
            tick();
        end
        memwrite_m = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            mem_ack = (i == 5);
            #1;
            check("t4_w2_req", mem_req, 1);
            check("t4_w2_addr", mem_addr, 32'h14);
            check("t4_w2_wdata", mem_wdata, 32'hBBBB0014);
            check("t4_w2_stall", stall_m, 0);
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check("t4_idle_req", mem_req, 0);
        check("t4_cnt", stall_cnt, 11);

        // Misaligned load, then an aligned store; the error flag is sticky.
        check("t5_mis0", misalign_err, 0);
        memread_m = 1'b1; aluout_m = 32'h83;
        #1 check("t5_stall", stall_m, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h00000005;
        #1;
        check("t5_addr", mem_addr, 32'h80);
        check("t5_mis", misalign_err, 1);
        tick();
        mem_ack = 1'b0;
        #1 check("t5_rdata", readdata_m, 32'h5);
        tick();
        memread_m = 1'b0;
        memwrite_m = 1'b1; aluout_m = 32'h20; writedata_m = 32'h77;
        tick();
        memwrite_m = 1'b0; mem_ack = 1'b1;
        #1 check("t5_st_addr", mem_addr, 32'h20);
        tick();
        mem_ack = 1'b0;
        #1;
        check("t5_mis_sticky", misalign_err, 1);
        check("t5_idle_req", mem_req, 0);

        // Reset asserted while a read is outstanding.
        memread_m = 1'b1; aluout_m = 32'h90;
        tick();
        #1 check("t6_rd_req", mem_req, 1);
        reset = 1'b0;
        #1;
        check("t6_req", mem_req, 0);
        check("t6_stall", stall_m, 0);
        check("t6_state", 32'(dut.state), 32'(IDLE));
        check("t6_cnt", stall_cnt, 0);
        check("t6_mis", misalign_err, 0);
        memread_m = 1'b0;
        tick();
        reset = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 2);
            #1;
            check("t6_quiet_req", mem_req, 0);
            check("t6_quiet_stall", stall_m, 0);
            tick();
        end
        mem_ack = 1'b0;
        #1 check("t6_rdata", readdata_m, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_if_m.md
Name: dmem_if_m

Overview:
- Memory-stage data-memory interface. Sits directly downstream of the pipelined datapath's MEM outputs (memwrite_m, aluout_m, writedata_m) and returns readdata_m.
- Replaces the ideal single-cycle data memory with a req/ack bus to a variable-latency memory.
- Contains a one-entry posted write buffer, so stores normally do not stall.
- Raises stall_m to the hazard unit, which freezes all pipeline registers, while a load is outstanding or a store cannot be buffered.

Parameters:
- AW, 32, byte address width of aluout_m / mem_addr.
- DW, 32, data width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- memread_m  in  1  MEM-stage load (memtoreg_m).
- memwrite_m  in  1  MEM-stage store.
- aluout_m  in  AW  byte address.
- writedata_m  in  DW  store data.
- readdata_m  out  DW  load result to the M/W register.
- stall_m  out  1  freeze request to the hazard unit.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- mem_wdata  out  DW  write data.
- mem_ack  in  1  transaction complete this cycle (meaningful only while mem_req=1).
- mem_rdata  in  DW  read data, valid with mem_ack on a read.
- misalign_err  out  1  sticky: an access with addr[1:0]!=0 occurred.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_m=1.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, write buffer invalid.
  - readdata_m=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - misalign_err=0, stall_cnt=0, stall_m=0.
  - Reset mid-transaction abandons the bus transaction; mem_req drops immediately.
- All bus outputs are registered, driven from state and the write-buffer contents.
- States:
  - IDLE: no read in flight. The write buffer may still be draining.
  - RD_REQ: read issued; mem_req=1, mem_we=0, held until mem_ack.
  - RD_DONE: one cycle. Captured data is presented on readdata_m and stall_m=0.
- Write buffer (wb_valid, wb_addr, wb_data):
  - While wb_valid and no read is in flight: mem_req=1, mem_we=1, mem_addr=wb_addr, mem_wdata=wb_data.
  - On mem_ack, wb_valid clears at that edge.
- Store (memwrite_m=1, stall_m=0):
  - Buffer empty, or draining with mem_ack this cycle: store is captured into the buffer at the edge. No stall.
  - Otherwise stall_m=1 until that condition holds.
- Load (memread_m=1):
  - From IDLE, stall_m=1 combinationally.
  - If wb_valid, wait for the drain to complete. This is the ordering rule; there is no store-to-load forwarding.
  - Then go to RD_REQ on the next edge. In RD_REQ, mem_ack latches mem_rdata into readdata_m and moves to RD_DONE.
  - RD_DONE: stall_m=0 and the pipeline advances. Return to IDLE on the next edge.
  - Minimum load latency with an empty buffer and ack on the first request cycle: 2 stall cycles, then the RD_DONE release cycle.
- readdata_m holds its last value when no load completes.
- memread_m and memwrite_m both 1 is illegal. The store wins and the load is ignored.
- Misalignment: any access with addr[1:0]!=0 sets misalign_err (sticky until reset). The access proceeds word-aligned.
- stall_cnt increments on every cycle with stall_m=1 and saturates at all-ones.
- mem_ack while mem_req=0 is ignored.
- Inputs are held stable by the pipeline while stall_m=1. The block samples them only at the capture edges defined above.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum logic [1:0] {IDLE, RD_REQ, RD_DONE} dmem_state_t.
  - Constant WORD_ALIGN_MASK.
- One sub-module: dmem_wbuf (one-entry write buffer with valid/accept/drain handshake).
- FSM, stall logic and the counter stay in dmem_if_m.

Test Plan:
- Store then idle: store addr 0x40, data 0xDEADBEEF, ack after 3 cycles.
  - Required: stall_m never 1.
  - Required: mem_req/mem_we=1 with addr 0x40, data 0xDEADBEEF until ack; then mem_req=0.
- Load, empty buffer: load 0x80, ack on first request cycle with rdata 0x12345678.
  - Required: stall_m=1 for 2 cycles, then 0.
  - Required: readdata_m=0x12345678 in RD_DONE; stall_cnt=2.
- Store immediately followed by load to the same address 0x100, write ack after 4 cycles, then read ack with 0xCAFEF00D.
  - Required: the read request is issued only after the write ack.
  - Required: readdata_m=0xCAFEF00D.
- Back-to-back stores to 0x10 and 0x14 with slow ack (5 cycles).
  - Required: the second store stalls until the first ack, then is buffered.
  - Required: both writes appear on the bus in order.
- Misaligned load at 0x83.
  - Required: mem_addr=0x80 and misalign_err=1.
  - Required: misalign_err stays 1 after subsequent aligned accesses until reset.
- Assert reset=0 during RD_REQ.
  - Required: mem_req=0, stall_m=0, state IDLE, stall_cnt=0 immediately.
  - Required: after reset release with no access, there is no bus activity.
